// File: rtl/pipe_stage_skid_pkg.sv
// Shared encodings and helpers for the skid-buffered pipeline stage.
package pipe_stage_skid_pkg;

    // Occupancy state of the two-entry stage; 2'd3 is unreachable.
    typedef enum logic [1:0] {
        PSK_EMPTY = 2'd0,
        PSK_ONE   = 2'd1,
        PSK_TWO   = 2'd2
    } psk_st_e;

    // Occupancy count reported on the perf/debug port.
    function automatic logic [1:0] occ_of(input psk_st_e st);
        case (st)
            PSK_ONE: occ_of = 2'd1;
            PSK_TWO: occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_dff.sv
// Enabled register with asynchronous active-low reset to a parameter value.
module pipe_stage_skid_dff #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d when enabled, otherwise hold.
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a two-entry skid buffer.
// up_ready_o depends on registered state only, so there is no combinational
// path from dn_ready_i back to the upstream stage.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int            DW      = 32,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          up_valid_i,
    output logic          up_ready_o,
    input  logic [DW-1:0] up_data_i,
    output logic          dn_valid_o,
    input  logic          dn_ready_i,
    output logic [DW-1:0] dn_data_o,
    output logic [1:0]    occ_o
);

    psk_st_e       st;
    psk_st_e       st_dec;
    psk_st_e       st_nxt;
    logic          up_fire;
    logic          dn_fire;
    logic          load_main;
    logic          main_en;
    logic          skid_en;
    logic [DW-1:0] main_d;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;

    // Fold the unreachable encoding onto EMPTY so every decode below is total.
    always_comb begin
        case (st)
            PSK_ONE: st_dec = PSK_ONE;
            PSK_TWO: st_dec = PSK_TWO;
            default: st_dec = PSK_EMPTY;
        endcase
    end

    assign dn_valid_o = (st_dec != PSK_EMPTY);
    assign up_ready_o = (st_dec != PSK_TWO);
    assign occ_o      = occ_of(st_dec);
    assign dn_data_o  = main_q;

    assign up_fire = up_valid_i & up_ready_o;
    assign dn_fire = dn_valid_o & dn_ready_i;

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= PSK_EMPTY;
        end else begin
            st <= st_nxt;
        end
    end

    // Next-state and main-register load decision; flush overrides the state only.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        st_nxt    = st_dec;
        load_main = 1'b0;
        case (st_dec)
            PSK_EMPTY: begin
                if (up_fire) begin
                    st_nxt    = PSK_ONE;
                    load_main = 1'b1;
                end
            end
            PSK_ONE: begin
                if (up_fire && dn_fire) begin
                    load_main = 1'b1;
                end else if (up_fire) begin
                    st_nxt = PSK_TWO;
                end else if (dn_fire) begin
                    st_nxt = PSK_EMPTY;
                end
            end
            PSK_TWO: begin
                if (dn_fire) begin
                    st_nxt    = PSK_ONE;
                    load_main = 1'b1;
                end
            end
            default: st_nxt = PSK_EMPTY;
        endcase
        if (flush_i) begin
            st_nxt = PSK_EMPTY;
        end
    end

    // Main takes fresh upstream data unless the older skid entry is promoted.
    assign main_d = (st_dec == PSK_ONE && up_fire && dn_fire) ? up_data_i :
                    (st_dec == PSK_TWO)                       ? skid_q    :
                                                                up_data_i;
    assign main_en = load_main & ~flush_i;
    assign skid_en = (st_dec == PSK_ONE) & up_fire & ~dn_fire & ~flush_i;

    // NOTE: the payload registers are reset too, so dn_data_o shows RST_VAL
    // out of reset instead of X; the cost is two flop rows with reset.
    pipe_stage_skid_dff #(.W(DW), .RST_VAL(RST_VAL)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_stage_skid_dff #(.W(DW), .RST_VAL(RST_VAL)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_en),
        .d     (up_data_i),
        .q     (skid_q)
    );

endmodule
